// File: rtl/store_narrow_pkg.sv
// Shared definitions for the store-narrowing path.
// Size codes, FSM state encoding, lane geometry and the alignment rule
// used by store_lane_gen and store_narrow.
package store_narrow_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  localparam logic [NUM_LANES-1:0] BE_ALL = 4'b1111;

  // Halfwords need addr[0]=0, words need addr[1:0]=0, size 11 is never legal.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane generator.
// Replicates a register value onto the byte lanes selected by size and the
// low address bits (little-endian) and produces the matching byte enables.
// Ports:
//   addr_lo    in  low two address bits
//   size       in  00 byte, 01 half, 10 word, 11 illegal
//   data       in  register value
//   wdata      out lane-replicated data
//   be         out byte enables (zero for an illegal size)
//   misaligned out request cannot be issued
module store_lane_gen
  import store_narrow_pkg::*;
(
  input  logic [1:0]                        addr_lo,
  input  logic [1:0]                        size,
  input  logic [31:0]                       data,
  output logic [NUM_LANES-1:0][LANE_W-1:0] wdata,
  output logic [NUM_LANES-1:0]              be,
  output logic                              misaligned
);

  assign misaligned = is_misaligned(size, addr_lo);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    // Lane i sources byte 0 for byte stores, byte i%2 for halfwords, byte i for words.
    always_comb begin
      wdata[i] = '0;
      be[i]    = 1'b0;
      case (size)
        SZ_BYTE: begin
          wdata[i] = data[7:0];
          be[i]    = (addr_lo == 2'(i));
        end
        SZ_HALF: begin
          wdata[i] = data[8*(i%2) +: 8];
          be[i]    = (addr_lo[1] == 1'(i/2));
        end
        SZ_WORD: begin
          wdata[i] = data[8*i +: 8];
          be[i]    = BE_ALL[i];
        end
        default: begin
          wdata[i] = '0;
          be[i]    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/store_narrow.sv
// Store narrowing and data-memory write issue.
// Accepts a store over valid/ready, narrows it to byte/half/word lanes,
// and holds a write strobe on the memory port until ack or timeout.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_addr/req_wdata/req_size    store address, register value, size code
//   mem_en/mem_addr/mem_wdata/mem_be  memory write, held until mem_ack
//   mem_ack                        memory accepted the write
//   misalign                       one-cycle pulse, request rejected
//   bus_err                        one-cycle pulse, ack timeout
//   bad_addr                       address of the last faulting request
//   busy                           write in progress
module store_narrow
  import store_narrow_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  output logic              misalign,
  output logic              bus_err,
  output logic [ADDR_W-1:0] bad_addr,
  output logic              busy
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [0:0] state;
  logic [7:0] cnt;
  logic [1:0] addr_lo;  // original low address bits, so bad_addr is exact on timeout

  logic [NUM_LANES-1:0][LANE_W-1:0] lane_wdata;
  logic [NUM_LANES-1:0]             lane_be;
  logic                             lane_bad;
  logic                             hs;

  store_lane_gen u_lane (
    .addr_lo    (req_addr[1:0]),
    .size       (req_size),
    .data       (req_wdata),
    .wdata      (lane_wdata),
    .be         (lane_be),
    .misaligned (lane_bad)
  );

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state == ST_WRITE);
  assign mem_en    = busy;  // strobe spans exactly the WRITE state
  assign hs        = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr_lo   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      bad_addr  <= '0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hs) begin
            if (lane_bad) begin
              misalign <= 1'b1;
              bad_addr <= req_addr;
            end else begin
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= lane_wdata;
              mem_be    <= lane_be;
              addr_lo   <= req_addr[1:0];
              cnt       <= '0;
              state     <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          // Ack takes priority over a timeout on the same edge.
          if (mem_ack) begin
            mem_be <= '0;
            state  <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            bus_err  <= 1'b1;
            bad_addr <= mem_addr | {{(ADDR_W-2){1'b0}}, addr_lo};
            mem_be   <= '0;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
